// File: rtl/ram2_rd_pkg.sv
// ---------------------------------------------------------------------------
// ram2_rd_pkg : shared types and helpers for the ram2 frame reader
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ram2_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One spare skid slot beyond the read latency keeps reads flowing at full rate.
  localparam int unsigned SKID_EXTRA = 1;

  function automatic int unsigned LAT(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

  function automatic int unsigned SKID_DEPTH(input int unsigned out_reg);
    return LAT(out_reg) + SKID_EXTRA;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram2_rd_skid_fifo.sv
// ---------------------------------------------------------------------------
// ram2_rd_skid_fifo : small register FIFO absorbing in-flight ram2 reads
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram2_rd_skid_fifo #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                  rd_clk_tb,
  input  logic                  tb_rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign full      = (occ_q == OCC_W'(DEPTH));
  assign empty     = (occ_q == '0);
  assign occupancy = occ_q;

endmodule

`default_nettype wire

// File: rtl/ram2_frame_reader.sv
// ---------------------------------------------------------------------------
// ram2_frame_reader : sweeps one ram2 frame per write-side toggle into a stream
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ram2_frame_reader
  import ram2_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned FRAME_LEN  = 1024,
  parameter int unsigned BASE_ADDR  = 0
) (
  input  logic                  rd_clk_tb,
  input  logic                  tb_rst,
  input  logic                  frame_tgl,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic                  overrun,
  output logic [15:0]           frame_cnt
);

  localparam int unsigned RD_LAT = LAT(OUT_REG);
  localparam int unsigned D      = SKID_DEPTH(OUT_REG);
  localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
  localparam int unsigned OCC_W  = $clog2(D + 1);
  localparam logic [CNT_W-1:0]      LEN_C  = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]      LAST_C = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE_C = ADDR_WIDTH'(BASE_ADDR);

  logic [2:0]            sync_q, sync_d;
  logic                  frame_req;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [RD_LAT-1:0]     vld_q, vld_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;

  logic                  issue;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [OCC_W-1:0]      fifo_occ;
  logic [DATA_WIDTH-1:0] fifo_head;
  int                    in_flight;

  // Two metastability flops, then a third copy used only for edge detection.
  assign sync_d    = {sync_q[1:0], frame_tgl};
  assign frame_req = sync_q[1] ^ sync_q[2];
  assign pop       = m_valid && m_ready;

  always_comb begin
    state_d     = state_q;
    rd_addr_d   = rd_addr_q;
    issue_cnt_d = issue_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    overrun_d   = overrun_q;
    frame_cnt_d = frame_cnt_q;
    issue       = 1'b0;
    in_flight   = 0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      in_flight = in_flight + int'(vld_q[i]);
    end

    if (frame_req && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
    if (pop) begin
      beat_cnt_d = beat_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_req) begin
          state_d     = READ;
          issue_cnt_d = '0;
          beat_cnt_d  = '0;
          rd_addr_d   = BASE_C;
        end
      end
      READ: begin
        // A beat leaving this cycle frees its slot, so it counts as a credit.
        issue = (issue_cnt_q < LEN_C) && (!fifo_full || pop) &&
                (int'(fifo_occ) + in_flight < int'(D) + int'(pop));
        if (issue) begin
          rd_addr_d   = rd_addr_q + 1'b1;
          issue_cnt_d = issue_cnt_q + 1'b1;
          if (issue_cnt_q == LAST_C) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (beat_cnt_q == LAST_C)) begin
          state_d     = IDLE;
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    vld_d    = vld_q << 1;
    vld_d[0] = issue;
  end

  always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
    if (tb_rst) begin
      sync_q      <= '0;
      state_q     <= IDLE;
      rd_addr_q   <= BASE_C;
      issue_cnt_q <= '0;
      beat_cnt_q  <= '0;
      vld_q       <= '0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      issue_cnt_q <= issue_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      vld_q       <= vld_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  ram2_rd_skid_fifo #(
    .DEPTH      (D),
    .DATA_WIDTH (DATA_WIDTH),
    .OCC_W      (OCC_W)
  ) u_skid (
    .rd_clk_tb (rd_clk_tb),
    .tb_rst    (tb_rst),
    .push      (vld_q[RD_LAT-1]),
    .push_data (rd_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .occupancy (fifo_occ)
  );

  assign rd_addr   = rd_addr_q;
  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_head;
  assign m_last    = m_valid && (beat_cnt_q == LAST_C);
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ram2_frame_reader.sv
// ---------------------------------------------------------------------------
// tb_ram2_frame_reader : scoreboard bench for two reader configurations
// Revision             : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ram2_frame_reader;

  localparam int unsigned LEN0  = 1024;
  localparam int unsigned BASE0 = 0;
  localparam int unsigned LEN1  = 8;
  localparam int unsigned BASE1 = 1020;

  logic        clk;
  logic        rst;
  logic        tgl0, tgl1;
  logic        rdy0, rdy1;
  logic [9:0]  d0_addr, d1_addr;
  logic [31:0] d0_rd_data, d1_rd_data, d1_q;
  logic [31:0] d0_data, d1_data;
  logic        d0_valid, d1_valid, d0_last, d1_last;
  logic        d0_busy, d1_busy, d0_ovr, d1_ovr;
  logic [15:0] d0_fcnt, d1_fcnt;

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];

  logic [32:0] exp0[$];
  logic [32:0] exp1[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rmode0   = 0;
  int rmode1   = 0;
  int beats    [2];
  int first_b  [2];
  int last_b   [2];
  int first_v  [2];
  int tgl_cyc  [2];
  int max_occ1 = 0;
  logic        stall0 = 1'b0, stall1 = 1'b0;
  logic [32:0] held0, held1;

  ram2_frame_reader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(0), .FRAME_LEN(LEN0), .BASE_ADDR(BASE0)
  ) u_dut0 (
    .rd_clk_tb(clk), .tb_rst(rst), .frame_tgl(tgl0), .rd_addr(d0_addr), .rd_data(d0_rd_data),
    .m_data(d0_data), .m_valid(d0_valid), .m_ready(rdy0), .m_last(d0_last),
    .busy(d0_busy), .overrun(d0_ovr), .frame_cnt(d0_fcnt)
  );

  ram2_frame_reader #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .OUT_REG(1), .FRAME_LEN(LEN1), .BASE_ADDR(BASE1)
  ) u_dut1 (
    .rd_clk_tb(clk), .tb_rst(rst), .frame_tgl(tgl1), .rd_addr(d1_addr), .rd_data(d1_rd_data),
    .m_data(d1_data), .m_valid(d1_valid), .m_ready(rdy1), .m_last(d1_last),
    .busy(d1_busy), .overrun(d1_ovr), .frame_cnt(d1_fcnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ram2 models: one-cycle read, and read plus output register
  always @(posedge clk) d0_rd_data <= mem0[d0_addr];
  always @(posedge clk) begin
    d1_q       <= mem1[d1_addr];
    d1_rd_data <= d1_q;
  end

  always @(posedge clk) cyc = cyc + 1;

  initial begin
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode0)
        0:       rdy0 = 1'b1;
        1:       rdy0 = (cyc % 3 == 0);
        default: rdy0 = 1'($urandom_range(0, 1));
      endcase
      case (rmode1)
        0:       rdy1 = 1'b1;
        1:       rdy1 = (cyc % 3 == 0);
        default: rdy1 = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_le(input string name, input int act, input int lim);
    n_checks++;
    if (act > lim) begin
      n_fail++;
      $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected frame: beat b reads address (BASE + b) mod 1024, last only on final beat.
  task automatic start_frame(input int sel);
    int unsigned len, base;
    len  = (sel == 0) ? LEN0 : LEN1;
    base = (sel == 0) ? BASE0 : BASE1;
    for (int b = 0; b < int'(len); b++) begin
      int unsigned a;
      a = (base + b) % 1024;
      if (sel == 0) exp0.push_back({(b == int'(len) - 1), mem0[a]});
      else          exp1.push_back({(b == int'(len) - 1), mem1[a]});
    end
    beats[sel]   = 0;
    first_b[sel] = -1;
    last_b[sel]  = -1;
    first_v[sel] = -1;
    tgl_cyc[sel] = cyc;
    if (sel == 0) tgl0 = ~tgl0;
    else          tgl1 = ~tgl1;
  endtask

  task automatic wait_beats(input int sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (beats[sel] >= n) break;
      tick(1);
    end
    check((sel == 0) ? "d0_beats_reached" : "d1_beats_reached", 64'(beats[sel]), 64'(n));
  endtask

  always @(negedge clk) begin
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) check("d0_stall_hold", {d0_valid, d0_last, d0_data}, {1'b1, held0});
      if (d0_valid && first_v[0] < 0) first_v[0] = cyc;
      if (d0_valid && rdy0) begin
        check("d0_scoreboard_nonempty", 64'(exp0.size() > 0), 64'(1));
        if (exp0.size() > 0) begin
          logic [32:0] e;
          e = exp0.pop_front();
          check("d0_data", d0_data, e[31:0]);
          check("d0_last", d0_last, e[32]);
        end
        beats[0]++;
        if (first_b[0] < 0) first_b[0] = cyc;
        last_b[0] = cyc;
      end
      stall0 = d0_valid && !rdy0;
      held0  = {d0_last, d0_data};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall1 = 1'b0;
    end else begin
      if (int'(u_dut1.u_skid.occupancy) > max_occ1) max_occ1 = int'(u_dut1.u_skid.occupancy);
      if (stall1) check("d1_stall_hold", {d1_valid, d1_last, d1_data}, {1'b1, held1});
      if (d1_valid && first_v[1] < 0) first_v[1] = cyc;
      if (d1_valid && rdy1) begin
        check("d1_scoreboard_nonempty", 64'(exp1.size() > 0), 64'(1));
        if (exp1.size() > 0) begin
          logic [32:0] e;
          e = exp1.pop_front();
          check("d1_data", d1_data, e[31:0]);
          check("d1_last", d1_last, e[32]);
        end
        beats[1]++;
        if (first_b[1] < 0) first_b[1] = cyc;
        last_b[1] = cyc;
      end
      stall1 = d1_valid && !rdy1;
      held1  = {d1_last, d1_data};
    end
  end

  task automatic check_reset_outputs();
    check("d0_rst_valid", d0_valid, 0);
    check("d0_rst_last", d0_last, 0);
    check("d0_rst_data", d0_data, 0);
    check("d0_rst_busy", d0_busy, 0);
    check("d0_rst_overrun", d0_ovr, 0);
    check("d0_rst_fcnt", d0_fcnt, 0);
    check("d0_rst_addr", d0_addr, BASE0);
    check("d1_rst_valid", d1_valid, 0);
    check("d1_rst_busy", d1_busy, 0);
    check("d1_rst_fcnt", d1_fcnt, 0);
    check("d1_rst_addr", d1_addr, BASE1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem0[i] = 32'(i);
      mem1[i] = $urandom;
    end
    for (int s = 0; s < 2; s++) begin
      beats[s] = 0; first_b[s] = -1; last_b[s] = -1; first_v[s] = -1; tgl_cyc[s] = 0;
    end
    rst  = 1'b1;
    tgl0 = 1'b0;
    tgl1 = 1'b0;
    tick(3);
    check_reset_outputs();
    rst = 1'b0;
    tick(3);

    // Short wrapped frames on the output-registered instance.
    for (int f = 0; f < 4; f++) begin
      rmode1 = (f == 0) ? 0 : ((f == 1) ? 1 : 2);
      for (int i = 0; i < 1024; i++) mem1[i] = $urandom;
      start_frame(1);
      wait_beats(1, LEN1, 300);
      tick(2);
      check("d1_busy_after", d1_busy, 0);
      check("d1_fcnt", d1_fcnt, 64'(f + 1));
      check("d1_queue_empty", 64'(exp1.size()), 0);
      if (f == 0) begin
        check_le("d1_first_valid_latency", first_v[1] - tgl_cyc[1], 6);
        check("d1_no_gaps", 64'(last_b[1] - first_b[1]), 64'(LEN1 - 1));
      end
    end
    check_le("d1_max_occupancy", max_occ1, 3);
    check("d1_overrun", d1_ovr, 0);

    // Full frame, ready always high.
    rmode0 = 0;
    start_frame(0);
    wait_beats(0, LEN0, 3000);
    tick(2);
    check_le("d0_first_valid_latency", first_v[0] - tgl_cyc[0], 5);
    check("d0_no_gaps", 64'(last_b[0] - first_b[0]), 64'(LEN0 - 1));
    check("d0_busy_after", d0_busy, 0);
    check("d0_fcnt_1", d0_fcnt, 1);

    // Ready on every third cycle.
    rmode0 = 1;
    start_frame(0);
    wait_beats(0, LEN0, 6000);
    tick(2);
    check("d0_fcnt_2", d0_fcnt, 2);
    check("d0_queue_empty_2", 64'(exp0.size()), 0);
    check("d0_overrun_clear", d0_ovr, 0);

    // Random ready with a second toggle mid-frame.
    rmode0 = 2;
    start_frame(0);
    wait_beats(0, 100, 3000);
    tgl0 = ~tgl0;
    wait_beats(0, LEN0, 6000);
    tick(20);
    check("d0_overrun_set", d0_ovr, 1);
    check("d0_fcnt_3", d0_fcnt, 3);
    check("d0_no_extra_frame", {d0_busy, d0_valid}, 0);

    // Reset mid-frame, then a clean restart.
    rmode0 = 0;
    start_frame(0);
    wait_beats(0, 500, 3000);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp0.delete();
    tgl0 = 1'b0;
    tgl1 = 1'b0;
    tick(3);
    check_reset_outputs();
    rst = 1'b0;
    tick(6);
    check("d0_quiet_after_rst", {d0_busy, d0_valid}, 0);
    rmode0 = 2;
    start_frame(0);
    wait_beats(0, LEN0, 6000);
    tick(2);
    check("d0_fcnt_after_rst", d0_fcnt, 1);
    check("d0_overrun_after_rst", d0_ovr, 0);
    check("d0_queue_empty_end", 64'(exp0.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram2_frame_reader.md
Name: ram2_frame_reader

Overview:
- Read-side controller for the ram2 simple dual-port buffer in the audio FFT/FIR path.
- The write side fills one frame and then flips a toggle. This block synchronises that toggle into the read clock domain and sweeps the ram2 read port over the frame.
- Read data is delivered as a valid/ready stream with a last-beat marker, running on rd_clk_tb and tolerating arbitrary downstream backpressure without losing or duplicating words.

Parameters:
- ADDR_WIDTH, 10: ram2 address width.
- DATA_WIDTH, 32: ram2 data width.
- OUT_REG, 0: 1 if ram2 has its output register enabled. Read latency LAT = 1 + OUT_REG.
- FRAME_LEN, 1024: words per frame, 1..2**ADDR_WIDTH.
- BASE_ADDR, 0: first address of the frame.

Ports:
- rd_clk_tb, in, 1: read clock.
- tb_rst, in, 1: reset, asynchronous, active-high.
- frame_tgl, in, 1: frame-complete toggle from the write clock domain; asynchronous to rd_clk_tb.
- rd_addr, out, ADDR_WIDTH: to ram2 rd_addr.
- rd_data, in, DATA_WIDTH: from ram2 rd_data.
- m_data, out, DATA_WIDTH: stream data.
- m_valid, out, 1: stream valid.
- m_ready, in, 1: stream ready.
- m_last, out, 1: high on the final beat of a frame.
- busy, out, 1: a frame is in progress.
- overrun, out, 1: sticky; a frame request arrived while busy.
- frame_cnt, out, 16: completed frames, wraps at 65535 -> 0.

Behaviour:
- Reset: all outputs are 0, rd_addr = BASE_ADDR, state IDLE, and the synchroniser flops are cleared. Reset asserted mid-frame aborts the frame immediately; no partial beats appear after release.
- Synchroniser: frame_tgl passes through 2 flops, then an edge-detect register. Any change of the synchronised value gives a 1-cycle frame_req. Toggle change to frame_req takes at most 3 cycles.
- States:
  - IDLE: on frame_req go to READ, set busy = 1, clear the issue and beat counters, and set rd_addr = BASE_ADDR.
  - READ: a read is issued when issue_cnt < FRAME_LEN and credits > 0.
    - Issuing a read advances rd_addr by 1, modulo 2**ADDR_WIDTH (wraps).
    - When issue_cnt reaches FRAME_LEN, go to DRAIN.
  - DRAIN: wait until every issued word has been accepted downstream, then go to IDLE with busy = 0 and frame_cnt + 1.
- Read pipeline:
  - A valid-bit shift register of depth LAT is aligned with rd_addr.
  - The word for the address held in rd_addr at edge k is captured from rd_data at edge k+LAT into the skid FIFO.
  - rd_addr holds its value when no read is issued.
- Skid FIFO:
  - Depth D = LAT + 1.
  - credits = D − (FIFO occupancy + reads in flight). This guarantees the FIFO never overflows.
  - Simultaneous push and pop in one cycle is legal; occupancy is unchanged.
- Stream:
  - m_valid = FIFO not empty; m_data is the FIFO head.
  - A beat transfers when m_valid && m_ready.
  - While m_valid is high and m_ready is low, m_data and m_last hold stable.
  - m_last is high exactly on beat index FRAME_LEN−1.
- Throughput: with m_ready held high, 1 beat per cycle sustained. First m_valid appears at most 3 + 1 + LAT cycles after the frame_tgl change.
- frame_req while busy: the request is dropped, overrun is set to 1 (cleared only by reset), and the current frame continues unaffected.
- frame_req in the same cycle as the DRAIN -> IDLE transition counts as busy, so it is also dropped and sets overrun.
- FRAME_LEN = 1: a single beat with m_last = 1.

Decomposition:
- Package ram2_rd_pkg holds:
  - the state enum (IDLE, READ, DRAIN);
  - the function LAT(OUT_REG);
  - the constant skid depth.
- One sub-module, ram2_rd_skid_fifo: a parameterised register FIFO with depth D, push/pop, full/empty and occupancy outputs.

Test Plan:
1. Preload ram2 word i = i. Toggle frame_tgl once with m_ready = 1 -> 1024 beats with data 0..1023, m_last only on data 1023, no gaps once streaming, then frame_cnt = 1 and busy = 0.
2. Same frame with m_ready = 1 only on every third cycle -> same ordered data 0..1023 with no duplicates or loss; m_data stable while stalled.
3. OUT_REG = 1 -> identical beat sequence to scenario 1, first m_valid no more than 6 cycles after the toggle; skid occupancy never exceeds 3.
4. BASE_ADDR = 1020, FRAME_LEN = 8 -> addresses 1020..1023, then 0..3; data matches, m_last on the 8th beat.
5. Second toggle at beat 100 of a frame -> overrun = 1, frame completes normally, frame_cnt = 1, no extra frame starts.
6. Assert tb_rst at beat 500, then release and toggle -> all outputs 0 during reset; the new frame restarts from data 0 and frame_cnt = 1 after it ends.
